// File: rtl/mem_bist_if.sv
// Request port between the BIST sequencer (master) and the memory controller (slave).
interface mem_bist_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 25
) ();
   logic [1:0]        cmd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              ready;
   logic              valid;

   modport master (output cmd, addr, wr_data, ready, input rd_data, valid);
   modport slave  (input cmd, addr, wr_data, ready, output rd_data, valid);
endinterface

// File: rtl/mem_bist_sequencer.sv
// Memory BIST sequencer: write pass then read/compare pass over [START_ADDR, END_ADDR].
// Optional watchdog compiled in with MEM_BIST_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start; done/pass hold the last result
// WR_ISSUE | write request presented (ready pulse)
// WR_WAIT  | waiting for controller valid on a write
// RD_ISSUE | read request presented (ready pulse)
// RD_WAIT  | waiting for valid, then compare rd_data
// FINISH   | result published, return to IDLE
module mem_bist_sequencer #(
   parameter int unsigned       DATA_W         = 16,
   parameter int unsigned       ADDR_W         = 25,
   parameter int unsigned       START_ADDR     = 0,
   parameter int unsigned       END_ADDR       = 255,
   parameter int unsigned       ERR_W          = 8,
   parameter logic [DATA_W-1:0] LFSR_SEED      = DATA_W'(16'hACE1),
   parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   mem_bist_if.master        bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              timeout
);

   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH} state_t;

   localparam logic [1:0]        CMD_NONE = 2'b00;
   localparam logic [1:0]        CMD_WR   = 2'b10;
   localparam logic [1:0]        CMD_RD   = 2'b01;
   localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
   localparam logic [ADDR_W-1:0] DW_A     = ADDR_W'(DATA_W);

   // Galois right-shift masks, maximal length for 8/16/32 bits.
   localparam logic [63:0] TAPS_64 = (DATA_W == 8)  ? 64'h0000_0000_0000_00B8 :
                                     (DATA_W == 16) ? 64'h0000_0000_0000_B400 :
                                     (DATA_W == 32) ? 64'h0000_0000_8020_0003 :
                                     ((64'h1 << (DATA_W - 1)) | 64'h1);
   localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(TAPS_64);

   state_t            state_q, state_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] lfsr_q, lfsr_d;

   logic [DATA_W-1:0] lfsr_nxt;
   logic [ADDR_W-1:0] addr_inc;
   logic              last_addr;
   logic              mismatch;
   logic [ERR_W-1:0]  err_inc;
   logic              in_wait;
   logic              wd_fire;

   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
      lfsr_step = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] l);
      logic [DATA_W+ADDR_W-1:0] ext;
      logic [2*DATA_W-1:0]      cb;
      ext = {{DATA_W{1'b0}}, a};
      cb  = {DATA_W{2'b01}};
      case (m)
         2'b00:   pattern = ext[DATA_W-1:0];
         2'b01:   pattern = a[0] ? ~cb[DATA_W-1:0] : cb[DATA_W-1:0];
         2'b10:   pattern = DATA_W'(1) << (a % DW_A);
         default: pattern = l;
      endcase
   endfunction

   assign lfsr_nxt  = lfsr_step(lfsr_q);
   assign addr_inc  = addr_q + 1'b1;
   assign last_addr = (addr_q == END_A);
   assign mismatch  = (bus.rd_data != pattern(mode_q, addr_q, lfsr_q));
   assign err_inc   = (&err_q) ? err_q : err_q + 1'b1;
   assign in_wait   = (state_q == WR_WAIT) || (state_q == RD_WAIT);

`ifdef MEM_BIST_TIMEOUT_EN
   localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_q;
   logic            to_q;

   assign wd_fire = in_wait && !bus.valid && (wd_q == '0);

   // Down-counter reloaded with every request; terminal count fires the watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else begin
         if (ready_d)
            wd_q <= WD_LOAD;
         else if (in_wait && (wd_q != '0))
            wd_q <= wd_q - 1'b1;
         if ((state_q == IDLE) && start)
            to_q <= 1'b0;
         else if (wd_fire)
            to_q <= 1'b1;
      end
   end

   assign timeout = to_q;
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= CMD_NONE;
         addr_q    <= '0;
         wr_data_q <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         first_q   <= '0;
         mode_q    <= 2'b00;
         lfsr_q    <= LFSR_SEED;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         first_q   <= first_d;
         mode_q    <= mode_d;
         lfsr_q    <= lfsr_d;
      end
   end

   // Next values of the output registers are decided here, so every output
   // reflects the state being entered on the same edge.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      ready_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      err_d     = err_q;
      first_d   = first_q;
      mode_d    = mode_q;
      lfsr_d    = lfsr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               done_d    = 1'b0;
               pass_d    = 1'b0;
               err_d     = '0;
               first_d   = '0;
               addr_d    = START_A;
               lfsr_d    = LFSR_SEED;
               mode_d    = mode;
               busy_d    = 1'b1;
               ready_d   = 1'b1;
               cmd_d     = CMD_WR;
               wr_data_d = pattern(mode, START_A, LFSR_SEED);
               state_d   = WR_ISSUE;
            end
         end
         WR_ISSUE: state_d = WR_WAIT;
         WR_WAIT: begin
            if (bus.valid) begin
               ready_d = 1'b1;
               if (last_addr) begin
                  addr_d  = START_A;
                  lfsr_d  = LFSR_SEED;
                  cmd_d   = CMD_RD;
                  state_d = RD_ISSUE;
               end else begin
                  addr_d    = addr_inc;
                  lfsr_d    = lfsr_nxt;
                  wr_data_d = pattern(mode_q, addr_inc, lfsr_nxt);
                  state_d   = WR_ISSUE;
               end
            end else if (wd_fire) begin
               cmd_d   = CMD_NONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               state_d = FINISH;
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (bus.valid) begin
               if (mismatch) begin
                  err_d = err_inc;
                  if (err_q == '0)
                     first_d = addr_q;
               end
               if (last_addr) begin
                  cmd_d   = CMD_NONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_q == '0) && !mismatch;
                  state_d = FINISH;
               end else begin
                  addr_d  = addr_inc;
                  lfsr_d  = lfsr_nxt;
                  ready_d = 1'b1;
                  state_d = RD_ISSUE;
               end
            end else if (wd_fire) begin
               cmd_d   = CMD_NONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd        = cmd_q;
   assign bus.addr       = addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.ready      = ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Directed bench for mem_bist_sequencer: echoing memory models with fixed latency,
// error injection, saturation, mid-pass reset and (with MEM_BIST_TIMEOUT_EN) the watchdog.
module tb_mem_bist_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] mode;
   logic start_a, start_b, start_c;

   always #5 clk = ~clk;

   mem_bist_if #(.DATA_W(16), .ADDR_W(25)) bus_a ();
   mem_bist_if #(.DATA_W(16), .ADDR_W(25)) bus_b ();
   mem_bist_if #(.DATA_W(16), .ADDR_W(25)) bus_c ();

   logic        busy_a, done_a, pass_a, to_a;
   logic [7:0]  err_a;
   logic [24:0] fea_a;
   logic        busy_b, done_b, pass_b, to_b;
   logic [7:0]  err_b;
   logic [24:0] fea_b;
   logic        busy_c, done_c, pass_c, to_c;
   logic [1:0]  err_c;
   logic [24:0] fea_c;

   mem_bist_sequencer #(.DATA_W(16), .ADDR_W(25), .START_ADDR(0), .END_ADDR(15), .ERR_W(8)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode), .bus(bus_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_err_addr(fea_a), .timeout(to_a));

   mem_bist_sequencer #(.DATA_W(16), .ADDR_W(25), .START_ADDR(32'h0FFFF), .END_ADDR(32'h0FFFF), .ERR_W(8)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode), .bus(bus_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_err_addr(fea_b), .timeout(to_b));

   mem_bist_sequencer #(.DATA_W(16), .ADDR_W(25), .START_ADDR(2), .END_ADDR(6), .ERR_W(2)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode), .bus(bus_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
      .first_err_addr(fea_c), .timeout(to_c));

`ifdef MEM_BIST_TIMEOUT_EN
   mem_bist_if #(.DATA_W(16), .ADDR_W(25)) bus_d ();
   logic        start_d, busy_d, done_d, pass_d, to_d;
   logic [7:0]  err_d;
   logic [24:0] fea_d;

   mem_bist_sequencer #(.DATA_W(16), .ADDR_W(25), .START_ADDR(0), .END_ADDR(3), .ERR_W(8),
                        .TIMEOUT_CYCLES(20)) u_d (
      .clk(clk), .rst(rst), .start(start_d), .mode(mode), .bus(bus_d),
      .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
      .first_err_addr(fea_d), .timeout(to_d));

   initial begin
      bus_d.valid   = 1'b0;
      bus_d.rd_data = 16'h0000;
      start_d       = 1'b0;
   end
`endif

   int checks   = 0;
   int failures = 0;

   // Memory model state, one slot per instance
   int          cnt [3];
   int          lat [3];
   logic [1:0]  p_cmd [3];
   logic [24:0] p_addr [3];
   logic [15:0] mem [3][256];
   int          wr_cnt [3];
   int          rd_cnt [3];
   int          wr_bad [3];
   logic [15:0] first_wd [3];
   logic [24:0] first_wa [3];
   bit          corrupt_all [3];
   int          corrupt_addr [3];
   bit          chk_wr [3];

   logic        mv_a, mv_b, mv_c;
   logic [15:0] md_a, md_b, md_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_pat(input logic [1:0] m, input logic [24:0] a);
      case (m)
         2'b00:   return a[15:0];
         2'b01:   return a[0] ? 16'hAAAA : 16'h5555;
         2'b10:   return 16'h0001 << a[3:0];
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_step(input int i, input logic rdy, input logic [1:0] c,
                             input logic [24:0] a, input logic [15:0] wd,
                             output logic v, output logic [15:0] d);
      v = 1'b0;
      d = 16'h0000;
      if (rst) begin
         cnt[i] = 0;
         return;
      end
      if (cnt[i] > 0) begin
         cnt[i]--;
         if (cnt[i] == 0) begin
            v = 1'b1;
            if (p_cmd[i] == 2'b01) begin
               d = mem[i][p_addr[i][7:0]];
               if (corrupt_all[i] || (int'(p_addr[i]) == corrupt_addr[i]))
                  d = d ^ 16'h0001;
            end
         end
      end
      if (rdy === 1'b1) begin
         p_cmd[i]  = c;
         p_addr[i] = a;
         cnt[i]    = lat[i];
         if (c == 2'b10) begin
            mem[i][a[7:0]] = wd;
            if (wr_cnt[i] == 0) begin
               first_wd[i] = wd;
               first_wa[i] = a;
            end
            wr_cnt[i]++;
            if (chk_wr[i] && (wd !== exp_pat(mode, a)))
               wr_bad[i]++;
         end else if (c == 2'b01) begin
            rd_cnt[i]++;
         end
      end
   endtask

   initial begin
      bus_a.valid = 1'b0; bus_a.rd_data = 16'h0000;
      forever begin
         @(negedge clk);
         model_step(0, bus_a.ready, bus_a.cmd, bus_a.addr, bus_a.wr_data, mv_a, md_a);
         bus_a.valid = mv_a; bus_a.rd_data = md_a;
      end
   end

   initial begin
      bus_b.valid = 1'b0; bus_b.rd_data = 16'h0000;
      forever begin
         @(negedge clk);
         model_step(1, bus_b.ready, bus_b.cmd, bus_b.addr, bus_b.wr_data, mv_b, md_b);
         bus_b.valid = mv_b; bus_b.rd_data = md_b;
      end
   end

   initial begin
      bus_c.valid = 1'b0; bus_c.rd_data = 16'h0000;
      forever begin
         @(negedge clk);
         model_step(2, bus_c.ready, bus_c.cmd, bus_c.addr, bus_c.wr_data, mv_c, md_c);
         bus_c.valid = mv_c; bus_c.rd_data = md_c;
      end
   end

   task automatic clear_model(input int i);
      wr_cnt[i] = 0;
      rd_cnt[i] = 0;
      wr_bad[i] = 0;
   endtask

   function automatic logic done_of(input int i);
      case (i)
         0: return done_a;
         1: return done_b;
         2: return done_c;
`ifdef MEM_BIST_TIMEOUT_EN
         3: return done_d;
`endif
         default: return 1'b0;
      endcase
   endfunction

   // Advance until done is seen (sampled #1 after each edge), bounded by budget.
   task automatic wait_done(input string tag, input int i, input int budget, inout int cycles);
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #1;
         cycles++;
         if (done_of(i)) break;
      end
      chk({tag, "_done_seen"}, {31'b0, done_of(i)}, 32'd1);
   endtask

   int cycles;
   bit found;

   initial begin
      rst = 1'b1; mode = 2'b00;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cnt[i] = 0; lat[i] = 3; corrupt_all[i] = 1'b0; corrupt_addr[i] = -1;
         chk_wr[i] = 1'b1; p_cmd[i] = 2'b00; p_addr[i] = '0;
         first_wd[i] = '0; first_wa[i] = '0;
         clear_model(i);
         for (int j = 0; j < 256; j++) mem[i][j] = 16'h0000;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd",   {30'b0, bus_a.cmd}, 32'd0);
      chk("rst_addr",  {7'b0, bus_a.addr}, 32'd0);
      chk("rst_wdata", {16'b0, bus_a.wr_data}, 32'd0);
      chk("rst_ready", {31'b0, bus_a.ready}, 32'd0);
      chk("rst_busy",  {31'b0, busy_a}, 32'd0);
      chk("rst_done",  {31'b0, done_a}, 32'd0);
      chk("rst_pass",  {31'b0, pass_a}, 32'd0);
      chk("rst_err",   {24'b0, err_a}, 32'd0);
      chk("rst_fea",   {7'b0, fea_a}, 32'd0);
      chk("rst_to",    {31'b0, to_a}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", {31'b0, bus_a.ready}, 32'd0);

      // Test 1: address-as-data, window 0..15, K=3 -> 130 cycles incl. start and done cycles
      clear_model(0); mode = 2'b00;
      @(posedge clk); #1; start_a = 1'b1; cycles = 1;
      @(posedge clk); #1; start_a = 1'b0; cycles++;
      chk("t1_ready_first", {31'b0, bus_a.ready}, 32'd1);
      chk("t1_busy_first",  {31'b0, busy_a}, 32'd1);
      chk("t1_cmd_first",   {30'b0, bus_a.cmd}, 32'd2);
      chk("t1_addr_first",  {7'b0, bus_a.addr}, 32'd0);
      @(posedge clk); #1; cycles++;
      chk("t1_ready_pulse", {31'b0, bus_a.ready}, 32'd0);
      chk("t1_cmd_stable",  {30'b0, bus_a.cmd}, 32'd2);
      wait_done("t1", 0, 400, cycles);
      chk("t1_cycles", cycles, 32'd130);
      chk("t1_pass",   {31'b0, pass_a}, 32'd1);
      chk("t1_err",    {24'b0, err_a}, 32'd0);
      chk("t1_busy",   {31'b0, busy_a}, 32'd0);
      chk("t1_cmd",    {30'b0, bus_a.cmd}, 32'd0);
      chk("t1_writes", wr_cnt[0], 32'd16);
      chk("t1_reads",  rd_cnt[0], 32'd16);
      chk("t1_wdata",  wr_bad[0], 32'd0);

      // Test 2: checkerboard, bit 0 flipped on read of addr 5, extra start pulse mid-test
      clear_model(0); mode = 2'b01; corrupt_addr[0] = 5;
      @(posedge clk); #1; start_a = 1'b1; cycles = 1;
      @(posedge clk); #1; start_a = 1'b0; cycles++;
      chk("t2_cleared_done", {31'b0, done_a}, 32'd0);
      repeat (40) begin @(posedge clk); #1; cycles++; end
      start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0; cycles++;
      wait_done("t2", 0, 400, cycles);
      chk("t2_cycles", cycles, 32'd130);
      chk("t2_err",    {24'b0, err_a}, 32'd1);
      chk("t2_fea",    {7'b0, fea_a}, 32'd5);
      chk("t2_pass",   {31'b0, pass_a}, 32'd0);
      chk("t2_writes", wr_cnt[0], 32'd16);
      chk("t2_reads",  rd_cnt[0], 32'd16);
      chk("t2_wdata",  wr_bad[0], 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_done_held", {31'b0, done_a}, 32'd1);
      chk("t2_pass_held", {31'b0, pass_a}, 32'd0);
      corrupt_addr[0] = -1;

      // Test 3: walking one
      clear_model(0); mode = 2'b10;
      @(posedge clk); #1; start_a = 1'b1; cycles = 1;
      @(posedge clk); #1; start_a = 1'b0; cycles++;
      wait_done("t3", 0, 400, cycles);
      chk("t3_pass",  {31'b0, pass_a}, 32'd1);
      chk("t3_err",   {24'b0, err_a}, 32'd0);
      chk("t3_wdata", wr_bad[0], 32'd0);

      // Test 4: reset during the 3rd read, then restart from START_ADDR
      clear_model(0); mode = 2'b00; corrupt_all[0] = 1'b1;
      @(posedge clk); #1; start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (rd_cnt[0] == 3) begin found = 1'b1; break; end
      end
      chk("t4_reached_rd3", {31'b0, found}, 32'd1);
      chk("t4_err_before",  {24'b0, err_a}, 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t4_cmd",   {30'b0, bus_a.cmd}, 32'd0);
      chk("t4_busy",  {31'b0, busy_a}, 32'd0);
      chk("t4_err",   {24'b0, err_a}, 32'd0);
      chk("t4_ready", {31'b0, bus_a.ready}, 32'd0);
      rst = 1'b0; corrupt_all[0] = 1'b0; clear_model(0);
      @(posedge clk); #1; start_a = 1'b1; cycles = 1;
      @(posedge clk); #1; start_a = 1'b0; cycles++;
      chk("t4_re_cmd",   {30'b0, bus_a.cmd}, 32'd2);
      chk("t4_re_addr",  {7'b0, bus_a.addr}, 32'd0);
      chk("t4_re_ready", {31'b0, bus_a.ready}, 32'd1);
      wait_done("t4", 0, 400, cycles);
      chk("t4_cycles", cycles, 32'd130);
      chk("t4_pass",   {31'b0, pass_a}, 32'd1);
      chk("t4_writes", wr_cnt[0], 32'd16);

      // Test 5: LFSR, single-address window 0x0FFFF -> 2*1*4+2 = 10 cycles
      clear_model(1); mode = 2'b11; chk_wr[1] = 1'b0;
      @(posedge clk); #1; start_b = 1'b1; cycles = 1;
      @(posedge clk); #1; start_b = 1'b0; cycles++;
      chk("t5_wdata_first", {16'b0, bus_b.wr_data}, 32'h0000ACE1);
      wait_done("t5", 1, 100, cycles);
      chk("t5_cycles",  cycles, 32'd10);
      chk("t5_writes",  wr_cnt[1], 32'd1);
      chk("t5_reads",   rd_cnt[1], 32'd1);
      chk("t5_wd",      {16'b0, first_wd[1]}, 32'h0000ACE1);
      chk("t5_wa",      {7'b0, first_wa[1]}, 32'h0000FFFF);
      chk("t5_pass",    {31'b0, pass_b}, 32'd1);
      chk("t5_err",     {24'b0, err_b}, 32'd0);

      // Test 6: ERR_W=2, every read corrupted over 5 addresses -> saturate at 3
      clear_model(2); mode = 2'b00; corrupt_all[2] = 1'b1;
      @(posedge clk); #1; start_c = 1'b1; cycles = 1;
      @(posedge clk); #1; start_c = 1'b0; cycles++;
      wait_done("t6", 2, 200, cycles);
      chk("t6_err",   {30'b0, err_c}, 32'd3);
      chk("t6_fea",   {7'b0, fea_c}, 32'd2);
      chk("t6_pass",  {31'b0, pass_c}, 32'd0);
      chk("t6_reads", rd_cnt[2], 32'd5);
      chk("t6_first_wa", {7'b0, first_wa[2]}, 32'd2);

`ifdef MEM_BIST_TIMEOUT_EN
      // Test 7: controller never answers, TIMEOUT_CYCLES=20 -> done 21 cycles after ready
      @(posedge clk); #1; start_d = 1'b1;
      @(posedge clk); #1; start_d = 1'b0;
      chk("t7_ready", {31'b0, bus_d.ready}, 32'd1);
      cycles = 0;
      wait_done("t7", 3, 100, cycles);
      chk("t7_cycles",  cycles, 32'd21);
      chk("t7_timeout", {31'b0, to_d}, 32'd1);
      chk("t7_pass",    {31'b0, pass_d}, 32'd0);
      chk("t7_busy",    {31'b0, busy_d}, 32'd0);
`endif

      chk("to_a_zero", {31'b0, to_a}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bist_sequencer.md
# mem_bist_sequencer

Parametrised built-in self-test sequencer that drives the `memory_controller` request port (`cmd` / `addr` / data / `ready` / `valid`) in place of the key/switch-driven `inOutControl` front end. On a start pulse it performs a write pass over a configurable address window, then a read-and-compare pass. Data comes from a selectable pattern generator. The block reports pass/fail, an error count and the first failing address. It sits between the board top level (start/status on keys and LEDs) and `memory_controller`, and is generalised in data width, address width, window and pattern mode.

## Interface
Parameters:
- `DATA_W`, 16: data width; matches the controller `dq` width.
- `ADDR_W`, 25: address width.
- `START_ADDR`, 0: first address of the window, inclusive.
- `END_ADDR`, 255: last address of the window, inclusive. `END_ADDR >= START_ADDR` is required.
- `ERR_W`, 8: width of `err_count`.
- `LFSR_SEED`, 16'hACE1: seed for the LFSR pattern. Must be nonzero.
- `TIMEOUT_CYCLES`, 1024: watchdog limit. Only used when `MEM_BIST_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a test. Sampled only in IDLE.
- `mode`, in, 2: pattern select. 00 = address-as-data (zero-extended or truncated to `DATA_W`). 01 = checkerboard (0x5555… on even addresses, 0xAAAA… on odd). 10 = walking one (`1 << (addr % DATA_W)`). 11 = LFSR.
- `cmd`, out, 2: one-hot command to the controller. 10 = WRITE, 01 = READ, 00 = none.
- `addr`, out, `ADDR_W`: request address.
- `wr_data`, out, `DATA_W`: write data.
- `rd_data`, in, `DATA_W`: read data from the controller. Valid while `valid` = 1.
- `ready`, out, 1: one-cycle pulse. Indicates `cmd`/`addr`/`wr_data` are driven.
- `valid`, in, 1: controller reports the command has finished.
- `busy`, out, 1: a test is in progress.
- `done`, out, 1: the test has finished. Held until the next start.
- `pass`, out, 1: result. Meaningful only when `done` = 1.
- `err_count`, out, `ERR_W`: number of miscompares. Saturates at all-ones.
- `first_err_addr`, out, `ADDR_W`: address of the first miscompare.
- `timeout`, out, 1: watchdog fired. Tied to 0 when the watchdog is not compiled in.

## Operation
- Every output is registered.
- Reset values: `cmd` = 00, `addr` = 0, `wr_data` = 0, `ready` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `first_err_addr` = 0, `timeout` = 0. The FSM resets to IDLE.
- FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH.
- IDLE, when `start` = 1:
  - clear `done`, `pass`, `err_count`, `first_err_addr`, `timeout`;
  - load the address counter with `START_ADDR`;
  - load the LFSR with `LFSR_SEED`;
  - latch `mode` for the whole test;
  - go to WR_ISSUE.
- WR_ISSUE: drive `ready` = 1, `cmd` = 10, current `addr`, pattern in `wr_data`. Go to WR_WAIT.
- WR_WAIT: `ready` = 0. `cmd`, `addr` and `wr_data` stay stable. On `valid`:
  - if `addr` == `END_ADDR`, reset the address counter to `START_ADDR`, re-seed the LFSR and go to RD_ISSUE;
  - otherwise increment the address, advance the LFSR one step and go to WR_ISSUE.
- RD_ISSUE: drive `ready` = 1, `cmd` = 01. Go to RD_WAIT.
- RD_WAIT: on `valid`, compare `rd_data` with the expected pattern for the current address.
  - On mismatch, increment `err_count` (saturating). If this is the first error, capture `first_err_addr`.
  - If `addr` == `END_ADDR`, go to FINISH. Otherwise advance as in WR_WAIT and go to RD_ISSUE.
- FINISH:
  - `cmd` = 00, `busy` = 0, `done` = 1;
  - `pass` = 1 only if there were no errors and no timeout;
  - go to IDLE.
- LFSR: Galois, `DATA_W` bits, maximal-length taps for 8, 16 and 32. Both passes start from the same seed, so the read pass reproduces the write sequence.
- Boundary conditions:
  - `start` while `busy` = 1 is ignored.
  - `valid` in IDLE, ISSUE or FINISH states is ignored.
  - `START_ADDR` == `END_ADDR` gives exactly one write and one read.
  - `rst` at any point, including mid-pass, returns to IDLE with reset values on the next edge. The pass is not resumed.

## Timing
- `start` high at edge N:
  - `busy` = 1 and `ready` = 1 from edge N+1;
  - `ready` is high for exactly one cycle.
- The next `ready` is asserted no earlier than the cycle after `valid` is seen, so there is at least one idle cycle between requests.
- A controller that answers `valid` K cycles after `ready` costs K+1 cycles per access.
- Total test length is 2·W·(K+1) + 2 cycles, where W = `END_ADDR` − `START_ADDR` + 1.
- `done` rises one cycle after the last read's `valid`.

## Configuration
- `MEM_BIST_TIMEOUT_EN` defined:
  - a watchdog counter clears on every `ready` and counts in WR_WAIT and RD_WAIT;
  - on reaching `TIMEOUT_CYCLES` without `valid`, it sets `timeout` = 1 and the FSM goes to FINISH with `pass` = 0.
- Undefined: no counter is built, `timeout` is constant 0, and the WAIT states wait forever.

## Test plan
- Address-as-data, `mode` = 00, window 0..15, model returns `valid` 3 cycles after `ready` and echoes stored data -> 16 WRITE then 16 READ pulses, `done` = 1, `pass` = 1, `err_count` = 0, total 130 cycles.
- Error injection, `mode` = 01, model flips bit 0 on the read of address 5 -> `err_count` = 1, `first_err_addr` = 5, `pass` = 0.
- LFSR, `mode` = 11, `DATA_W` = 16, `START_ADDR` = `END_ADDR` = 0x0FFFF -> one write of 16'hACE1 to 0x0FFFF, one read, `pass` = 1.
- `rst` asserted during the 3rd read -> next cycle `cmd` = 00, `busy` = 0, `err_count` = 0. A following `start` replays from `START_ADDR` with the write pass.
- `start` pulsed again mid-test -> ignored, same request count as a single run. Saturation check: `ERR_W` = 2, model corrupts every read -> `err_count` = 3.
- With `MEM_BIST_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20, model never asserts `valid` -> `timeout` = 1 and `done` = 1 at 21 cycles after `ready`, `pass` = 0.
